octree_bfs_addr_gen: RTL and testbench
======================================

// Module: octree_bfs_addr_gen
// PURPOSE
//  Breadth-first traversal engine for the octree stored in node memory; produces the BFS-side
//  read address and the select that steer the octree/BFS address mux onto the node memory.
//  Walks from a root node, fetches each node word, queues child addresses in a FIFO, and
//  streams every visited node (address + child mask) to the downstream consumer.
// PARAMETERS
//  ADDR_SIZE   16  node memory address width (words)
//  DATA_W      24  node word width: [7:0] child mask, [23:8] first-child address
//  FIFO_DEPTH  16  pending-node queue depth, power of 2, >=2
// PORTS
//  i_clk         in   1          clock, rising edge
//  i_rst_n       in   1          synchronous active-low reset
//  i_start       in   1          start traversal (sampled only in IDLE)
//  i_root_addr   in   ADDR_SIZE  root node address, sampled with i_start
//  o_rd_en       out  1          node memory read strobe
//  o_addr_bfs    out  ADDR_SIZE  node memory read address (to mux BFS input)
//  o_select      out  1          1 = BFS owns memory bus (to mux select)
//  i_rd_data     in   DATA_W     node word, valid exactly 1 cycle after o_rd_en
//  o_node_valid  out  1          one-cycle pulse per visited node
//  o_node_addr   out  ADDR_SIZE  visited node address
//  o_node_mask   out  8          visited node child mask
//  o_node_count  out  16         nodes visited this traversal
//  o_busy        out  1          traversal in progress
//  o_done        out  1          one-cycle pulse at end of traversal
//  o_overflow    out  1          sticky: child dropped because FIFO was full
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): state IDLE, FIFO emptied, all outputs 0, count 0, overflow 0.
//  Reset mid-traversal aborts immediately; no o_done pulse.
//  FSM: IDLE -> ISSUE -> WAIT -> {EXPAND | ISSUE | DONE}; EXPAND -> {ISSUE | DONE}; DONE -> IDLE.
//  IDLE: i_start=1 -> push i_root_addr, clear count and overflow, o_busy=o_select=1, go ISSUE.
//  ISSUE: pop FIFO head into node reg; o_rd_en=1, o_addr_bfs=head for this cycle; go WAIT.
//  WAIT: capture i_rd_data; o_node_valid=1, o_node_addr=node reg, o_node_mask=data[7:0];
//   count+1 (wraps at 2^16); mask!=0 -> EXPAND; else FIFO nonempty -> ISSUE, empty -> DONE.
//  EXPAND: one set mask bit per cycle, lowest index first; k-th set bit (k=0..) pushes
//   base+k (mod 2^ADDR_SIZE, wraps); cycles = popcount(mask); then ISSUE, or DONE if FIFO empty.
//  Push when FIFO full: child dropped, o_overflow set (sticky until next start), traversal continues.
//  DONE: o_done=1 one cycle, o_busy/o_select fall to 0 same cycle as o_done, go IDLE.
//  o_select=1 in ISSUE/WAIT/EXPAND (all states between start and DONE); o_addr_bfs holds
//   last value when o_rd_en=0; o_node_addr/o_node_mask hold until next o_node_valid.
//  i_start ignored outside IDLE. Push and pop never in the same cycle.
//  Per node latency: start->first o_rd_en 1 cycle; o_rd_en->o_node_valid 1 cycle.
// STRUCTURE
//  Shared package/header: ADDR_SIZE, node word field offsets (MASK_LSB=0, PTR_LSB=8), FSM
//   state encodings.
//  One sub-module: bfs_fifo (sync FIFO, FIFO_DEPTH x ADDR_SIZE, push/pop/full/empty, sync
//   active-low reset); the FSM, mask-scan and address adder stay in this module.
// TESTING
//  1 root 0x0040 with mask 0x00 -> one o_rd_en @0x0040, one node_valid, o_done, count=1,
//    overflow=0.
//  2 root 0x0000 {mask 0x81, ptr 0x0100}, children leaves -> reads 0x0000,0x0100,0x0101
//    in order, count=3.
//  3 mask 0x0F, ptr 0xFFFE -> children pushed 0xFFFE,0xFFFF,0x0000,0x0001 (wrap).
//  4 FIFO_DEPTH=4, root mask 0xFF, all children leaves -> 4 children visited, o_overflow=1,
//    count=5, o_done asserted.
//  5 i_start pulsed while o_busy=1 -> ignored; read sequence and count unchanged.
//  6 i_rst_n=0 in EXPAND -> next cycle all outputs 0, IDLE, no o_done; new start runs
//    cleanly from empty FIFO.

Source files
------------

// File: rtl/octree_bfs_addr_gen_pkg.sv
// Shared constants for the octree BFS address generator: node word layout and FSM states.
package octree_bfs_addr_gen_pkg;

  localparam int ADDR_SIZE = 16;
  localparam int MASK_LSB  = 0;
  localparam int MASK_W    = 8;
  localparam int PTR_LSB   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EXPAND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/octree_bfs_addr_gen_fifo.sv
// Pending-node queue: synchronous show-ahead FIFO, head visible the cycle after a push.
module bfs_fifo import octree_bfs_addr_gen_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int WIDTH = ADDR_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_reg;
  logic [PW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB tells full (wrapped once) apart from empty.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[PW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/octree_bfs_addr_gen.sv
// Breadth-first octree walker: issues node reads, expands child masks into a FIFO of
// pending addresses and streams each visited node downstream.
module octree_bfs_addr_gen import octree_bfs_addr_gen_pkg::*; #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [ADDR_SIZE-1:0] i_root_addr,
  output logic                 o_rd_en,
  output logic [ADDR_SIZE-1:0] o_addr_bfs,
  output logic                 o_select,
  input  logic [DATA_W-1:0]    i_rd_data,
  output logic                 o_node_valid,
  output logic [ADDR_SIZE-1:0] o_node_addr,
  output logic [7:0]           o_node_mask,
  output logic [15:0]          o_node_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);

  state_t               state_reg, state_next;
  logic [ADDR_SIZE-1:0] node_reg, base_reg, addr_hold_reg, out_addr_reg;
  logic [7:0]           mask_reg, out_mask_reg, mask_rest;
  logic [2:0]           k_reg;
  logic [15:0]          count_reg;
  logic                 overflow_reg;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_SIZE-1:0] fifo_wr_data, fifo_head;
  logic [7:0]           rd_mask;
  logic [ADDR_SIZE-1:0] rd_ptr;

  assign rd_mask   = i_rd_data[MASK_LSB +: MASK_W];
  assign rd_ptr    = i_rd_data[PTR_LSB +: ADDR_SIZE];
  // Clearing the lowest set bit walks children in ascending bit order.
  assign mask_rest = mask_reg & (mask_reg - 8'd1);

  bfs_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_SIZE)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next   = state_reg;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_wr_data = base_reg + ADDR_SIZE'(k_reg);
    unique case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          fifo_push    = 1'b1;
          fifo_wr_data = i_root_addr;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fifo_pop   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_mask != 8'd0)  state_next = ST_EXPAND;
        else if (!fifo_empty) state_next = ST_ISSUE;
        else                  state_next = ST_DONE;
      end
      ST_EXPAND: begin
        fifo_push = 1'b1;
        if (mask_rest == 8'd0)
          state_next = (fifo_empty && fifo_full) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rd_en      = (state_reg == ST_ISSUE);
    o_addr_bfs   = (state_reg == ST_ISSUE) ? fifo_head : addr_hold_reg;
    o_busy       = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT) ||
                   (state_reg == ST_EXPAND);
    o_select     = o_busy;
    o_done       = (state_reg == ST_DONE);
    o_node_valid = (state_reg == ST_WAIT);
    o_node_addr  = (state_reg == ST_WAIT) ? node_reg : out_addr_reg;
    o_node_mask  = (state_reg == ST_WAIT) ? rd_mask : out_mask_reg;
    o_node_count = count_reg;
    o_overflow   = overflow_reg;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      node_reg      <= '0;
      base_reg      <= '0;
      addr_hold_reg <= '0;
      out_addr_reg  <= '0;
      mask_reg      <= '0;
      out_mask_reg  <= '0;
      k_reg         <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
          end
        end
        ST_ISSUE: begin
          node_reg      <= fifo_head;
          addr_hold_reg <= fifo_head;
        end
        ST_WAIT: begin
          out_addr_reg <= node_reg;
          out_mask_reg <= rd_mask;
          mask_reg     <= rd_mask;
          base_reg     <= rd_ptr;
          k_reg        <= '0;
          count_reg    <= count_reg + 16'd1;
        end
        ST_EXPAND: begin
          mask_reg <= mask_rest;
          k_reg    <= k_reg + 3'd1;
          if (fifo_full) overflow_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_octree_bfs_addr_gen.sv
// Directed bench for octree_bfs_addr_gen with a 4-deep queue and a sparse node memory model.
module tb_octree_bfs_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] root_addr;
  logic        rd_en;
  logic [15:0] addr_bfs;
  logic        select;
  logic [23:0] rd_data;
  logic        node_valid;
  logic [15:0] node_addr;
  logic [7:0]  node_mask;
  logic [15:0] node_count;
  logic        busy;
  logic        done;
  logic        overflow;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_busy_err = 0;

  logic [23:0] mem [logic [15:0]];
  logic [15:0] rd_log [$];
  int          rd_cyc [$];
  logic [15:0] nv_addr [$];
  logic [7:0]  nv_mask [$];
  int          nv_cyc [$];

  octree_bfs_addr_gen #(
    .DATA_W     (24),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_root_addr  (root_addr),
    .o_rd_en      (rd_en),
    .o_addr_bfs   (addr_bfs),
    .o_select     (select),
    .i_rd_data    (rd_data),
    .o_node_valid (node_valid),
    .o_node_addr  (node_addr),
    .o_node_mask  (node_mask),
    .o_node_count (node_count),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mem_word(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 24'h0;
  endfunction

  always @(posedge clk) begin
    rd_data <= rd_en ? mem_word(addr_bfs) : 24'h0;
    cyc++;
  end

  always @(negedge clk) begin
    if (rd_en) begin
      rd_log.push_back(addr_bfs);
      rd_cyc.push_back(cyc);
    end
    if (node_valid) begin
      nv_addr.push_back(node_addr);
      nv_mask.push_back(node_mask);
      nv_cyc.push_back(cyc);
      $display("node %04h mask %02h count %0d", node_addr, node_mask, node_count);
    end
    if (done) begin
      done_cnt++;
      if (busy || select) done_busy_err++;
    end
  end

  task automatic clear_logs();
    rd_log.delete(); rd_cyc.delete();
    nv_addr.delete(); nv_mask.delete(); nv_cyc.delete();
    done_cnt = 0;
  endtask

  // Pulses start, optionally re-pulses it at loop step spurious_at, waits for o_done.
  task automatic run_traversal(input logic [15:0] root, input int budget,
                               input int spurious_at, output int s_cyc, output bit to);
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; root_addr = root; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; root_addr = 16'h0777;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      start = (i == spurious_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt != 0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; root_addr = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({rd_en, select, node_valid, busy, done, overflow} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 000000",
               {rd_en, select, node_valid, busy, done, overflow});
    end
    compared++;
    if ({addr_bfs, node_addr, node_mask, node_count} !== 56'h0) begin
      mismatched++;
      $display("FAIL reset_values: got %h expected 0", {addr_bfs, node_addr, node_mask, node_count});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_leaf();
    int s; bit to;
    mem.delete();
    run_traversal(16'h0040, 50, -1, s, to);
    compared++;
    if (to) begin mismatched++; $display("FAIL leaf_timeout: got no done expected done"); end
    compared++;
    if (rd_log.size() != 1 || rd_log[0] !== 16'h0040) begin
      mismatched++;
      $display("FAIL leaf_reads: got %0d reads first %h expected 1 read 0040",
               rd_log.size(), rd_log.size() > 0 ? rd_log[0] : 16'hxxxx);
    end
    compared++;
    if (nv_addr.size() != 1) begin
      mismatched++; $display("FAIL leaf_nodes: got %0d expected 1", nv_addr.size());
    end
    compared++;
    if (rd_cyc.size() < 1 || rd_cyc[0] - s != 1) begin
      mismatched++; $display("FAIL leaf_start_latency: got %0d expected 1",
                             rd_cyc.size() > 0 ? rd_cyc[0] - s : -1);
    end
    compared++;
    if (nv_cyc.size() < 1 || rd_cyc.size() < 1 || nv_cyc[0] - rd_cyc[0] != 1) begin
      mismatched++; $display("FAIL leaf_read_latency: got %0d expected 1",
                             (nv_cyc.size() > 0 && rd_cyc.size() > 0) ? nv_cyc[0] - rd_cyc[0] : -1);
    end
    compared++;
    if (node_count !== 16'd1 || overflow !== 1'b0 || done_cnt != 1) begin
      mismatched++;
      $display("FAIL leaf_status: got count %0d ovf %b done %0d expected 1 0 1",
               node_count, overflow, done_cnt);
    end
    $display("leaf traversal checked");
  endtask

  task automatic test_two_children();
    int s; bit to;
    logic [15:0] exp_a [3] = '{16'h0000, 16'h0100, 16'h0101};
    logic [7:0]  exp_m [3] = '{8'h81, 8'h00, 8'h00};
    mem.delete();
    mem[16'h0000] = {16'h0100, 8'h81};
    run_traversal(16'h0000, 100, -1, s, to);
    compared++;
    if (to) begin mismatched++; $display("FAIL two_timeout: got no done expected done"); end
    compared++;
    if (rd_log.size() != 3) begin
      mismatched++; $display("FAIL two_read_count: got %0d expected 3", rd_log.size());
    end
    for (int i = 0; i < 3 && i < rd_log.size() && i < nv_mask.size(); i++) begin
      compared++;
      if (rd_log[i] !== exp_a[i] || nv_mask[i] !== exp_m[i]) begin
        mismatched++;
        $display("FAIL two_read%0d: got %h/%h expected %h/%h",
                 i, rd_log[i], nv_mask[i], exp_a[i], exp_m[i]);
      end
    end
    compared++;
    if (rd_cyc.size() < 2 || nv_cyc.size() < 1 || rd_cyc[1] - nv_cyc[0] != 3) begin
      mismatched++; $display("FAIL two_expand_cycles: got %0d expected 3",
                             (rd_cyc.size() > 1 && nv_cyc.size() > 0) ? rd_cyc[1] - nv_cyc[0] : -1);
    end
    compared++;
    if (node_count !== 16'd3 || node_addr !== 16'h0101 || node_mask !== 8'h00) begin
      mismatched++;
      $display("FAIL two_final: got count %0d addr %h mask %h expected 3 0101 00",
               node_count, node_addr, node_mask);
    end
    compared++;
    if (done_busy_err != 0) begin
      mismatched++; $display("FAIL done_busy: got %0d expected 0", done_busy_err);
    end
    $display("two-children traversal checked");
  endtask

  task automatic test_wrap();
    int s; bit to;
    logic [15:0] exp_a [5] = '{16'h0200, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    mem.delete();
    mem[16'h0200] = {16'hFFFE, 8'h0F};
    run_traversal(16'h0200, 100, -1, s, to);
    compared++;
    if (to || rd_log.size() != 5) begin
      mismatched++; $display("FAIL wrap_reads: got %0d reads (timeout %b) expected 5", rd_log.size(), to);
    end
    for (int i = 0; i < 5 && i < rd_log.size(); i++) begin
      compared++;
      if (rd_log[i] !== exp_a[i]) begin
        mismatched++; $display("FAIL wrap_read%0d: got %h expected %h", i, rd_log[i], exp_a[i]);
      end
    end
    compared++;
    if (node_count !== 16'd5 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_status: got count %0d ovf %b expected 5 0", node_count, overflow);
    end
    $display("wrap traversal checked");
  endtask

  task automatic test_overflow();
    int s; bit to;
    logic [15:0] exp_a [5] = '{16'h0300, 16'h0400, 16'h0401, 16'h0402, 16'h0403};
    mem.delete();
    mem[16'h0300] = {16'h0400, 8'hFF};
    run_traversal(16'h0300, 100, -1, s, to);
    compared++;
    if (to || rd_log.size() != 5) begin
      mismatched++; $display("FAIL ovf_reads: got %0d reads (timeout %b) expected 5", rd_log.size(), to);
    end
    for (int i = 0; i < 5 && i < rd_log.size(); i++) begin
      compared++;
      if (rd_log[i] !== exp_a[i]) begin
        mismatched++; $display("FAIL ovf_read%0d: got %h expected %h", i, rd_log[i], exp_a[i]);
      end
    end
    compared++;
    if (rd_cyc.size() < 2 || nv_cyc.size() < 1 || rd_cyc[1] - nv_cyc[0] != 9) begin
      mismatched++; $display("FAIL ovf_expand_cycles: got %0d expected 9",
                             (rd_cyc.size() > 1 && nv_cyc.size() > 0) ? rd_cyc[1] - nv_cyc[0] : -1);
    end
    compared++;
    if (node_count !== 16'd5 || overflow !== 1'b1 || done_cnt != 1) begin
      mismatched++;
      $display("FAIL ovf_status: got count %0d ovf %b done %0d expected 5 1 1",
               node_count, overflow, done_cnt);
    end
    $display("overflow traversal checked");
  endtask

  task automatic test_start_ignored();
    int s; bit to;
    logic [15:0] exp_a [3] = '{16'h0500, 16'h0600, 16'h0601};
    mem.delete();
    mem[16'h0500] = {16'h0600, 8'h03};
    mem[16'h0777] = {16'h0800, 8'h01};
    run_traversal(16'h0500, 100, 2, s, to);
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (to || rd_log.size() != 3) begin
      mismatched++; $display("FAIL busy_start_reads: got %0d reads (timeout %b) expected 3", rd_log.size(), to);
    end
    for (int i = 0; i < 3 && i < rd_log.size(); i++) begin
      compared++;
      if (rd_log[i] !== exp_a[i]) begin
        mismatched++; $display("FAIL busy_start_read%0d: got %h expected %h", i, rd_log[i], exp_a[i]);
      end
    end
    compared++;
    if (node_count !== 16'd3 || overflow !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_start_status: got count %0d ovf %b busy %b expected 3 0 0",
               node_count, overflow, busy);
    end
    $display("start-while-busy checked");
  endtask

  task automatic test_reset_in_expand();
    int s; bit to;
    mem.delete();
    mem[16'h0800] = {16'h0900, 8'hF0};
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; root_addr = 16'h0800; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 5) begin
      @(posedge clk); #1;
    end
    compared++;
    if (busy !== 1'b1 || rd_log.size() != 1) begin
      mismatched++; $display("FAIL expand_busy: got busy %b reads %0d expected 1 1", busy, rd_log.size());
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    compared++;
    if ({rd_en, select, node_valid, busy, done, overflow} !== 6'b0 ||
        {addr_bfs, node_addr, node_mask, node_count} !== 56'h0) begin
      mismatched++;
      $display("FAIL expand_reset_outputs: got %b %h expected all 0",
               {rd_en, select, node_valid, busy, done, overflow},
               {addr_bfs, node_addr, node_mask, node_count});
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (done_cnt != 0) begin
      mismatched++; $display("FAIL expand_reset_done: got %0d expected 0", done_cnt);
    end
    mem.delete();
    mem[16'h0A00] = {16'h0B00, 8'h01};
    run_traversal(16'h0A00, 100, -1, s, to);
    compared++;
    if (to || rd_log.size() != 2 || rd_log[0] !== 16'h0A00 || rd_log[1] !== 16'h0B00) begin
      mismatched++;
      $display("FAIL post_reset_reads: got %0d reads (timeout %b) expected 0a00,0b00",
               rd_log.size(), to);
    end
    compared++;
    if (node_count !== 16'd2) begin
      mismatched++; $display("FAIL post_reset_count: got %0d expected 2", node_count);
    end
    $display("reset-in-expand checked");
  endtask

  initial begin
    test_reset();
    test_leaf();
    test_two_children();
    test_wrap();
    test_overflow();
    test_start_ignored();
    test_reset_in_expand();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
